// File: rtl/traffic_pkg.sv
// Shared types and default sizing for the lane congestion estimator.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    OCCUPIED = 2'd2
  } lane_state_t;

  localparam int DEF_NUM_LANES     = 4;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_WINDOW_CYCLES = 1000;
  localparam int DEF_MIN_PRESENCE  = 4;
  localparam int DEF_HI_THRESH     = 12;
  localparam int DEF_LO_THRESH     = 6;

endpackage

// File: rtl/lane_vehicle_counter.sv
// One lane: loop synchroniser, presence-qualifying FSM and saturating vehicle counter.
//   state    | meaning
//   IDLE     | loop low, waiting for presence
//   ARMING   | loop high, not yet long enough to be a vehicle
//   OCCUPIED | vehicle present; counted when the loop releases
module lane_vehicle_counter
  import traffic_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MIN_PRESENCE = DEF_MIN_PRESENCE
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             loop_det_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int PW = (MIN_PRESENCE > 1) ? $clog2(MIN_PRESENCE) : 1;
  localparam logic [PW-1:0] ARM_LOAD = (MIN_PRESENCE > 1) ? PW'(MIN_PRESENCE - 2) : '0;

  logic             sync1_q, sync2_q;
  lane_state_t      state_q, state_d;
  logic [PW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] count_q;
  logic             depart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= loop_det_i;
      sync2_q <= sync1_q;
    end
  end

  // rem_q holds the further high cycles still needed after the next one
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (sync2_q) begin
          if (MIN_PRESENCE == 1) begin
            state_d = OCCUPIED;
          end else begin
            state_d = ARMING;
            rem_d   = ARM_LOAD;
          end
        end
      end
      ARMING: begin
        if (!sync2_q)          state_d = IDLE;
        else if (rem_q == '0)  state_d = OCCUPIED;
        else                   rem_d   = rem_q - PW'(1);
      end
      OCCUPIED: begin
        if (!sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!enable_i) begin
      state_d = IDLE;
      rem_d   = '0;
    end
  end

  assign depart  = enable_i && (state_q == OCCUPIED) && !sync2_q;
  assign count_o = (depart && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      count_q <= clear_i ? '0 : count_o;
    end
  end

endmodule

// File: rtl/lane_congestion_estimator.sv
// Per-lane windowed vehicle counts with hysteretic congestion flags.
// Optional peak tracking (clear_peak / peak_count) when CONGESTION_PEAK_EN is defined.
module lane_congestion_estimator
  import traffic_pkg::*;
#(
  parameter int NUM_LANES     = DEF_NUM_LANES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int MIN_PRESENCE  = DEF_MIN_PRESENCE,
  parameter int HI_THRESH     = DEF_HI_THRESH,
  parameter int LO_THRESH     = DEF_LO_THRESH
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_LANES-1:0]       loop_det,
`ifdef CONGESTION_PEAK_EN
  input  logic                       clear_peak,
  output logic [NUM_LANES*CNT_W-1:0] peak_count,
`endif
  output logic                       window_tick,
  output logic [NUM_LANES*CNT_W-1:0] last_count,
  output logic [NUM_LANES-1:0]       congested
);

  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(WINDOW_CYCLES - 1);

  logic [TW-1:0]              timer_q, timer_d;
  logic                       terminal;
  logic                       tick_q;
  logic [NUM_LANES*CNT_W-1:0] last_q, last_d;
  logic [NUM_LANES-1:0]       cong_q, cong_d;
  logic [CNT_W-1:0]           lane_cnt [NUM_LANES];

  // Timer counts down the cycles remaining in the window; zero is the terminal cycle.
  assign terminal = enable && (timer_q == '0);

  always_comb begin
    if (!enable || terminal) timer_d = TIMER_LOAD;
    else                     timer_d = timer_q - TW'(1);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_vehicle_counter #(
      .CNT_W        (CNT_W),
      .MIN_PRESENCE (MIN_PRESENCE)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .enable_i   (enable),
      .clear_i    (terminal || !enable),
      .loop_det_i (loop_det[g]),
      .count_o    (lane_cnt[g])
    );
  end

  // lane_cnt already includes a departure landing on the terminal cycle.
  always_comb begin
    last_d = last_q;
    cong_d = cong_q;
    if (terminal) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        last_d[i*CNT_W +: CNT_W] = lane_cnt[i];
        if (int'(lane_cnt[i]) >= HI_THRESH)      cong_d[i] = 1'b1;
        else if (int'(lane_cnt[i]) <= LO_THRESH) cong_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= TIMER_LOAD;
      tick_q  <= 1'b0;
      last_q  <= '0;
      cong_q  <= '0;
    end else begin
      timer_q <= timer_d;
      tick_q  <= terminal;
      last_q  <= last_d;
      cong_q  <= cong_d;
    end
  end

  assign window_tick = tick_q;
  assign last_count  = last_q;
  assign congested   = cong_q;

`ifdef CONGESTION_PEAK_EN
  logic [NUM_LANES*CNT_W-1:0] peak_q, peak_d;

  // A clear coinciding with a tick restarts the peak from the new window.
  always_comb begin
    peak_d = peak_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (tick_q) begin
        if (clear_peak || (last_q[i*CNT_W +: CNT_W] > peak_q[i*CNT_W +: CNT_W]))
          peak_d[i*CNT_W +: CNT_W] = last_q[i*CNT_W +: CNT_W];
      end else if (clear_peak) begin
        peak_d[i*CNT_W +: CNT_W] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) peak_q <= '0;
    else      peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`endif

endmodule
